// File: rtl/trail_logic.sv
// Motion-trail overlay: ring buffer of the last P_DEPTH committed (x, y) points,
// each drawn as a (P_SCALE+1)-pixel square, with the age of the newest covering point.
module trail_logic #(
   parameter int P_DATA_W = 11,
   parameter int P_SCALE  = 2,
   parameter int P_DEPTH  = 8,
   parameter int P_IDX_W  = 3
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [P_DATA_W-1:0] i_hcount,
   input  logic [P_DATA_W-1:0] i_vcount,
   input  logic [P_DATA_W-1:0] i_x_val,
   input  logic [P_DATA_W-1:0] i_y_val,
   input  logic                i_vals_valid,
   input  logic                i_frame_start,
   input  logic                i_clear,
   output logic                o_pixel_on,
   output logic [P_IDX_W-1:0]  o_pixel_age,
   output logic [P_IDX_W:0]    o_count
);

   logic [P_DATA_W-1:0] stg_x;
   logic [P_DATA_W-1:0] stg_y;
   logic                pend;
   logic [P_DATA_W-1:0] ent_x [P_DEPTH];
   logic [P_DATA_W-1:0] ent_y [P_DEPTH];
   logic [P_IDX_W-1:0]  wr_ptr;
   logic [P_IDX_W:0]    count;
   logic                commit;
   logic [P_DATA_W-1:0] cmt_x;
   logic [P_DATA_W-1:0] cmt_y;
   logic [P_IDX_W-1:0]  slot_age;
   logic                hit_p0;
   logic [P_IDX_W-1:0]  age_p0;
   logic                pixel_on_p1;
   logic [P_IDX_W-1:0]  age_p1;

   function automatic logic [P_IDX_W:0] sat_inc(input logic [P_IDX_W:0] c);
      if (c >= (P_IDX_W+1)'(P_DEPTH))
         return (P_IDX_W+1)'(P_DEPTH);
      else
         return c + (P_IDX_W+1)'(1);
   endfunction

   // Extra top bit keeps a square near the maximum coordinate clipped instead of wrapped.
   function automatic logic in_span(input logic [P_DATA_W-1:0] pos,
                                    input logic [P_DATA_W-1:0] base);
      logic [P_DATA_W:0] hi;
      hi = {1'b0, base} + (P_DATA_W+1)'(P_SCALE);
      return ({1'b0, pos} >= {1'b0, base}) && ({1'b0, pos} <= hi);
   endfunction

   // A strobe coinciding with frame start bypasses staging.
   assign commit = i_frame_start && (pend || i_vals_valid);
   assign cmt_x  = i_vals_valid ? i_x_val : stg_x;
   assign cmt_y  = i_vals_valid ? i_y_val : stg_y;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr <= '0;
         count  <= '0;
         pend   <= 1'b0;
      end else if (i_clear) begin
         wr_ptr <= '0;
         count  <= '0;
         pend   <= 1'b0;
      end else begin
         if (commit) begin
            wr_ptr <= wr_ptr + P_IDX_W'(1);
            count  <= sat_inc(count);
         end
         if (i_frame_start)
            pend <= 1'b0;
         else if (i_vals_valid)
            pend <= 1'b1;
      end
   end

   // Payload storage; validity is carried entirely by count and pend.
   always_ff @(posedge i_clk) begin
      if (i_vals_valid) begin
         stg_x <= i_x_val;
         stg_y <= i_y_val;
      end
      if (commit) begin
         ent_x[wr_ptr] <= cmt_x;
         ent_y[wr_ptr] <= cmt_y;
      end
   end

   // ---- stage p0: parallel compares and min-age reduction ----
   always_comb begin
      hit_p0   = 1'b0;
      age_p0   = '0;
      slot_age = '0;
      for (int k = 0; k < P_DEPTH; k++) begin
         slot_age = wr_ptr - P_IDX_W'(1) - P_IDX_W'(k);
         if (({1'b0, slot_age} < count) &&
             in_span(i_hcount, ent_x[k]) && in_span(i_vcount, ent_y[k]) &&
             (!hit_p0 || (slot_age < age_p0))) begin
            hit_p0 = 1'b1;
            age_p0 = slot_age;
         end
      end
   end

   // ---- stage p1: registered overlay outputs ----
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         pixel_on_p1 <= 1'b0;
         age_p1      <= '0;
      end else begin
         pixel_on_p1 <= hit_p0;
         age_p1      <= age_p0;
      end
   end

   assign o_pixel_on  = pixel_on_p1;
   assign o_pixel_age = age_p1;
   assign o_count     = count;

endmodule
